// File: rtl/dmem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_pkg : FSM encoding, wait-counter width and default signature address
// Rev 1.0
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int          CNT_W           = 4;
  localparam logic [31:0] DEFAULT_SIG_ADR = 32'h14;

  // Counter preload for the BUSY phase; WAIT_CYCLES=0 skips BUSY entirely.
  function automatic logic [CNT_W-1:0] cnt_load(input int wait_cycles);
    return (wait_cycles == 0) ? '0 : CNT_W'(wait_cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_ram : single-port synchronous 2^DEPTH_LOG2 x 32 RAM, per-lane writes
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_ram #(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  input  logic                  rd_en,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Read register doubles as the zero-when-idle readdata output.
  always_ff @(posedge clk) begin
    if (reset)      rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
    else            rdata <= '0;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_wait_responder : wait-state data-memory responder with signature capture
// Optional feature macro: DMEM_BYTE_WRITE_EN (adds byteen lane mask)
// Rev 1.0
// ---------------------------------------------------------------------------
module dmem_wait_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 6,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] SIG_ADR     = DEFAULT_SIG_ADR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]  byteen,
`endif
  output logic [31:0] readdata,
  output logic        ready,
  output logic        sig_valid,
  output logic [31:0] sig_data,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = cnt_load(WAIT_CYCLES);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  req, is_write, is_read;
  logic                  misaligned, out_of_range, hit_sig, acc_err;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            lanes, ram_we;
  logic                  rd_en, commit_wr;
  logic [31:0]           sig_merge;

  assign req          = memread | memwrite;
  assign is_write     = memwrite;
  assign is_read      = memread & ~memwrite;
  assign word_idx     = adr[DEPTH_LOG2+1:2];
  assign misaligned   = |adr[1:0];
  assign out_of_range = |adr[31:DEPTH_LOG2+2];
  assign hit_sig      = (adr[31:2] == SIG_ADR[31:2]);
  assign acc_err      = misaligned | out_of_range | (memread & memwrite);

`ifdef DMEM_BYTE_WRITE_EN
  assign lanes = byteen;
`else
  assign lanes = 4'hF;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = (WAIT_CYCLES == 0) ? RESP : BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (!req)             state_nxt = IDLE;
        else if (cnt == '0)   state_nxt = RESP;
        else                  cnt_nxt   = cnt - CNT_W'(1);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write commits at the end of RESP; reads are fetched on entry to RESP.
  assign commit_wr = (state == RESP) && is_write && !reset;
  assign ram_we    = (commit_wr && !out_of_range) ? lanes : 4'h0;
  assign rd_en     = (state_nxt == RESP) && is_read && !out_of_range && !reset;

  always_comb begin
    sig_merge = sig_data;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) sig_merge[8*i +: 8] = writedata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ready     <= 1'b0;
      sig_valid <= 1'b0;
      sig_data  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ready     <= (state_nxt == RESP);
      sig_valid <= commit_wr && hit_sig;
      if (commit_wr && hit_sig) sig_data <= sig_merge;
      if ((state == IDLE) && req && acc_err) err <= 1'b1;
    end
  end

  dmem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .addr  (word_idx),
    .we    (ram_we),
    .wdata (writedata),
    .rd_en (rd_en),
    .rdata (readdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_dmem_wait_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_wait_responder : directed bench for WAIT_CYCLES=2 and WAIT_CYCLES=0
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memread = 1'b0, memwrite = 1'b0;
  logic [31:0] adr = '0, writedata = '0;
  logic [31:0] readdata, sig_data;
  logic        ready, sig_valid, err;

  logic        memread0 = 1'b0, memwrite0 = 1'b0;
  logic [31:0] adr0 = '0, writedata0 = '0;
  logic [31:0] readdata0, sig_data0;
  logic        ready0, sig_valid0, err0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  byteen = 4'hF;
  logic [3:0]  byteen0 = 4'hF;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_wait_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(2), .SIG_ADR(32'h14)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .adr(adr), .writedata(writedata),
`ifdef DMEM_BYTE_WRITE_EN
    .byteen(byteen),
`endif
    .readdata(readdata), .ready(ready), .sig_valid(sig_valid),
    .sig_data(sig_data), .err(err)
  );

  dmem_wait_responder #(.DEPTH_LOG2(6), .WAIT_CYCLES(0), .SIG_ADR(32'h14)) dut0 (
    .clk(clk), .reset(reset), .memread(memread0), .memwrite(memwrite0),
    .adr(adr0), .writedata(writedata0),
`ifdef DMEM_BYTE_WRITE_EN
    .byteen(byteen0),
`endif
    .readdata(readdata0), .ready(ready0), .sig_valid(sig_valid0),
    .sig_data(sig_data0), .err(err0)
  );

  // Drives one access on dut; lat = cycle index (0 = request first seen) of ready, -1 on timeout.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int lat, output logic [31:0] rdat, output logic sv);
    @(posedge clk); #1;
    memread = rd; memwrite = wr; adr = a; writedata = d;
`ifdef DMEM_BYTE_WRITE_EN
    byteen = be;
`else
    if (be != 4'hF) $display("note: byte lanes ignored in this build");
`endif
    lat  = -1;
    rdat = 32'hDEAD_BEEF;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ready) begin
        lat  = n;
        rdat = readdata;
        break;
      end
    end
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    sv = sig_valid;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0)     begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
    checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL reset_sig_valid: got %b expected 0", sig_valid); end
    checks++; if (sig_data !== 32'h0) begin errors++; $display("FAIL reset_sig_data: got %h expected 0", sig_data); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    #1 reset = 1'b0;
  endtask

  task automatic test_signature();
    int lat; logic [31:0] rdat; logic sv;
    access(1'b0, 1'b1, 32'h14, 32'h15, 4'hF, lat, rdat, sv);
    checks++; if (lat !== 3)          begin errors++; $display("FAIL sig_wr_latency: got %0d expected 3", lat); end
    checks++; if (rdat !== 32'h0)     begin errors++; $display("FAIL sig_wr_readdata: got %h expected 0", rdat); end
    checks++; if (sv !== 1'b1)        begin errors++; $display("FAIL sig_valid_pulse: got %b expected 1", sv); end
    checks++; if (sig_data !== 32'h15) begin errors++; $display("FAIL sig_data: got %h expected 15", sig_data); end
    @(negedge clk);
    checks++; if (sig_valid !== 1'b0) begin errors++; $display("FAIL sig_valid_one_cycle: got %b expected 0", sig_valid); end
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (lat !== 3)          begin errors++; $display("FAIL sig_rd_latency: got %0d expected 3", lat); end
    checks++; if (rdat !== 32'h15)    begin errors++; $display("FAIL sig_rd_data: got %h expected 15", rdat); end
    checks++; if (sv !== 1'b0)        begin errors++; $display("FAIL sig_valid_on_read: got %b expected 0", sv); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL sig_err: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back();
    logic        rd_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] a_t  [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] d_t  [4] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0};
    logic [31:0] e_t  [4] = '{32'h0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      memread0 = rd_t[i]; memwrite0 = ~rd_t[i]; adr0 = a_t[i]; writedata0 = d_t[i];
      @(negedge clk);
      checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL b2b_idle_%0d: ready got %b expected 0", i, ready0); end
      @(negedge clk);
      checks++;
      if (ready0 !== 1'b1 || readdata0 !== e_t[i]) begin
        errors++;
        $display("FAIL b2b_resp_%0d: ready/readdata got %b/%h expected 1/%h", i, ready0, readdata0, e_t[i]);
      end
    end
    @(posedge clk); #1;
    memread0 = 1'b0; memwrite0 = 1'b0;
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rdat; logic sv; logic seen;
    access(1'b0, 1'b1, 32'h8, 32'hCAFE_0008, 4'hF, lat, rdat, sv);
    @(posedge clk); #1;
    memwrite = 1'b1; adr = 32'h8; writedata = 32'hDEAD_0008;
    @(posedge clk); #1;
    memwrite = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_ready: got %b expected 0", seen); end
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (rdat !== 32'hCAFE_0008) begin errors++; $display("FAIL abort_old_value: got %h expected cafe0008", rdat); end
  endtask

  task automatic test_addr_errors();
    int lat; logic [31:0] rdat; logic sv;
    access(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (lat !== 3 || rdat !== 32'h0) begin errors++; $display("FAIL oor_read: lat/data got %0d/%h expected 3/0", lat, rdat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", err); end
    do_reset();
    access(1'b0, 1'b1, 32'h6, 32'h0000_0066, 4'hF, lat, rdat, sv);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b expected 1", err); end
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (rdat !== 32'h66) begin errors++; $display("FAIL misalign_commit: got %h expected 66", rdat); end
  endtask

  task automatic test_both_and_reset();
    int lat; logic [31:0] rdat; logic sv; logic seen;
    do_reset();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
    access(1'b1, 1'b1, 32'h10, 32'h7, 4'hF, lat, rdat, sv);
    checks++; if (lat !== 3 || rdat !== 32'h0) begin errors++; $display("FAIL both_as_write: lat/data got %0d/%h expected 3/0", lat, rdat); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL both_err: got %b expected 1", err); end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (rdat !== 32'h7) begin errors++; $display("FAIL both_readback: got %h expected 7", rdat); end
    @(posedge clk); #1;
    memwrite = 1'b1; adr = 32'h10; writedata = 32'h99;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0; memwrite = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_busy_ready: got %b expected 0", seen); end
    checks++; if (err !== 1'b0)  begin errors++; $display("FAIL reset_busy_err: got %b expected 0", err); end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (rdat !== 32'h7) begin errors++; $display("FAIL reset_busy_nowrite: got %h expected 7", rdat); end
  endtask

`ifdef DMEM_BYTE_WRITE_EN
  task automatic test_byte_write();
    int lat; logic [31:0] rdat; logic sv;
    access(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, lat, rdat, sv);
    access(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'b0011, lat, rdat, sv);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, lat, rdat, sv);
    checks++; if (rdat !== 32'hAABB_3344) begin errors++; $display("FAIL byte_merge: got %h expected aabb3344", rdat); end
  endtask
`endif

  initial begin
    test_reset();
    test_signature();
    test_back_to_back();
    test_abort();
    test_addr_errors();
    test_both_and_reset();
`ifdef DMEM_BYTE_WRITE_EN
    test_byte_write();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
